// File: rtl/xadrez_pkg.sv
// Shared definitions for the chess move path: FSM states, error codes
// and the width of a packed board square.
package xadrez_pkg;

    typedef enum logic {
        ESPERA_ORIGEM  = 1'b0,
        ESPERA_DESTINO = 1'b1
    } estado_t;

    localparam logic [1:0] ERRO_FAIXA = 2'b01;
    localparam logic [1:0] ERRO_NULO  = 2'b10;
    localparam logic [1:0] ERRO_TEMPO = 2'b11;

    localparam int LARGURA_CASA = 6;

endpackage

// File: rtl/temporizador_jogada.sv
// Destination-wait timer: counts idle cycles while a move is half entered
// and flags the cycle on which the wait budget runs out.
module temporizador_jogada
    import xadrez_pkg::*;
#(
    parameter int TIMEOUT = 1000
) (
    input  logic clock,
    input  logic reset,
    input  logic limpa,
    input  logic conta,
    output logic estouro
);

    localparam int LARGURA = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [LARGURA-1:0] LIMITE = LARGURA'(TIMEOUT - 1);

    logic [LARGURA-1:0] tempo;

    // The overflow is only meaningful on a cycle that is actually counting,
    // so a strobe or cancel on the limit cycle never raises it.
    assign estouro = conta && (tempo == LIMITE);

    // Counter is forced to zero whenever the caller is not waiting idle.
    always_ff @(posedge clock) begin
        if (reset || limpa) begin
            tempo <= '0;
        end else if (conta) begin
            tempo <= estouro ? '0 : tempo + 1'b1;
        end
    end

endmodule

// File: rtl/receptor_jogadas.sv
// Pairs consecutive coordinate strobes into origin/destination moves,
// range-checks them, rejects null and stalled moves, and reports each
// outcome with a one-cycle pronto or erro pulse.
module receptor_jogadas
    import xadrez_pkg::*;
#(
    parameter int TIMEOUT = 1000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    novaJogada,
    input  logic [3:0]              coluna,
    input  logic [3:0]              linha,
    input  logic                    cancela,
    output logic [LARGURA_CASA-1:0] origem,
    output logic [LARGURA_CASA-1:0] destino,
    output logic                    pronto,
    output logic                    erro,
    output logic [1:0]              codigoErro,
    output logic                    aguardandoDestino,
    output logic [7:0]              contaJogadas
);

    estado_t                 estado, estadoProx;
    logic [LARGURA_CASA-1:0] origemProx, destinoProx, casa;
    logic                    prontoProx, erroProx, faixaOk;
    logic [1:0]              codigoProx;
    logic [7:0]              contaProx;
    logic                    contaTimer, limpaTimer, estouro;

    assign faixaOk = ~coluna[3] & ~linha[3];
    assign casa    = {linha[2:0], coluna[2:0]};

    // The timer only runs on idle destination-wait cycles; cancel and strobe
    // outrank the timeout, so either of them stops it counting.
    assign contaTimer = (estado == ESPERA_DESTINO) && !cancela && !novaJogada;
    assign limpaTimer = !contaTimer;

    temporizador_jogada #(
        .TIMEOUT (TIMEOUT)
    ) uTemporizador (
        .clock   (clock),
        .reset   (reset),
        .limpa   (limpaTimer),
        .conta   (contaTimer),
        .estouro (estouro)
    );

    assign aguardandoDestino = (estado == ESPERA_DESTINO);

    // Next-state and next-output decode; everything holds unless an event acts.
    always_comb begin
        estadoProx  = estado;
        origemProx  = origem;
        destinoProx = destino;
        prontoProx  = 1'b0;
        erroProx    = 1'b0;
        codigoProx  = codigoErro;
        contaProx   = contaJogadas;
        case (estado)
            ESPERA_ORIGEM: begin
                if (novaJogada) begin
                    if (faixaOk) begin
                        origemProx = casa;
                        estadoProx = ESPERA_DESTINO;
                    end else begin
                        erroProx   = 1'b1;
                        codigoProx = ERRO_FAIXA;
                    end
                end
            end
            ESPERA_DESTINO: begin
                if (cancela) begin
                    estadoProx = ESPERA_ORIGEM;
                end else if (novaJogada) begin
                    estadoProx = ESPERA_ORIGEM;
                    if (!faixaOk) begin
                        erroProx   = 1'b1;
                        codigoProx = ERRO_FAIXA;
                    end else if (casa == origem) begin
                        erroProx   = 1'b1;
                        codigoProx = ERRO_NULO;
                    end else begin
                        destinoProx = casa;
                        prontoProx  = 1'b1;
                        contaProx   = contaJogadas + 8'd1;
                    end
                end else if (estouro) begin
                    estadoProx = ESPERA_ORIGEM;
                    erroProx   = 1'b1;
                    codigoProx = ERRO_TEMPO;
                end
            end
            default: estadoProx = ESPERA_ORIGEM;
        endcase
    end

    // State and all visible outputs are registered together.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado       <= ESPERA_ORIGEM;
            origem       <= '0;
            destino      <= '0;
            pronto       <= 1'b0;
            erro         <= 1'b0;
            codigoErro   <= 2'b00;
            contaJogadas <= 8'd0;
        end else begin
            estado       <= estadoProx;
            origem       <= origemProx;
            destino      <= destinoProx;
            pronto       <= prontoProx;
            erro         <= erroProx;
            codigoErro   <= codigoProx;
            contaJogadas <= contaProx;
        end
    end

endmodule

// File: tb/tb_receptor_jogadas.sv
// Directed bench for receptor_jogadas with a short timeout of 4 cycles.
module tb_receptor_jogadas;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       novaJogada = 1'b0;
    logic [3:0] coluna = 4'd0;
    logic [3:0] linha = 4'd0;
    logic       cancela = 1'b0;
    logic [5:0] origem, destino;
    logic       pronto, erro, aguardandoDestino;
    logic [1:0] codigoErro;
    logic [7:0] contaJogadas;

    int testsRun = 0;
    int failCount = 0;

    receptor_jogadas #(
        .TIMEOUT (4)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .novaJogada        (novaJogada),
        .coluna            (coluna),
        .linha             (linha),
        .cancela           (cancela),
        .origem            (origem),
        .destino           (destino),
        .pronto            (pronto),
        .erro              (erro),
        .codigoErro        (codigoErro),
        .aguardandoDestino (aguardandoDestino),
        .contaJogadas      (contaJogadas)
    );

    always #5 clock = ~clock;

    // Drives one cycle of inputs; returns 1 time unit after the sampling edge.
    task automatic applyStimulus(input logic nova, input logic [3:0] c, input logic [3:0] l,
                                 input logic canc, input logic rst);
        novaJogada = nova;
        coluna     = c;
        linha      = l;
        cancela    = canc;
        reset      = rst;
        @(posedge clock);
        #1;
        novaJogada = 1'b0;
        cancela    = 1'b0;
        reset      = 1'b0;
    endtask

    task automatic test_reset();
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
        testsRun++; if (origem !== 6'o00) begin failCount++; $display("[TB] FAIL reset_origem: got %o expected 00", origem); end
        testsRun++; if (destino !== 6'o00) begin failCount++; $display("[TB] FAIL reset_destino: got %o expected 00", destino); end
        testsRun++; if ({pronto, erro, aguardandoDestino} !== 3'b000) begin failCount++; $display("[TB] FAIL reset_flags: got %b expected 000", {pronto, erro, aguardandoDestino}); end
        testsRun++; if (codigoErro !== 2'b00) begin failCount++; $display("[TB] FAIL reset_codigo: got %b expected 00", codigoErro); end
        testsRun++; if (contaJogadas !== 8'd0) begin failCount++; $display("[TB] FAIL reset_conta: got %0d expected 0", contaJogadas); end
    endtask

    task automatic test_basic_move();
        applyStimulus(1'b1, 4'd1, 4'd2, 1'b0, 1'b0);
        testsRun++; if (origem !== 6'o21) begin failCount++; $display("[TB] FAIL basic_origem: got %o expected 21", origem); end
        testsRun++; if ({aguardandoDestino, pronto} !== 2'b10) begin failCount++; $display("[TB] FAIL basic_wait: got %b expected 10", {aguardandoDestino, pronto}); end
        applyStimulus(1'b1, 4'd4, 4'd5, 1'b0, 1'b0);
        testsRun++; if (destino !== 6'o54) begin failCount++; $display("[TB] FAIL basic_destino: got %o expected 54", destino); end
        testsRun++; if ({pronto, erro, aguardandoDestino} !== 3'b100) begin failCount++; $display("[TB] FAIL basic_pulse: got %b expected 100", {pronto, erro, aguardandoDestino}); end
        testsRun++; if (contaJogadas !== 8'd1) begin failCount++; $display("[TB] FAIL basic_conta: got %0d expected 1", contaJogadas); end
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
        testsRun++; if (pronto !== 1'b0) begin failCount++; $display("[TB] FAIL basic_pulse_len: got %b expected 0", pronto); end
    endtask

    task automatic test_null_move();
        applyStimulus(1'b1, 4'd3, 4'd3, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd3, 4'd3, 1'b0, 1'b0);
        testsRun++; if ({pronto, erro, aguardandoDestino} !== 3'b010) begin failCount++; $display("[TB] FAIL null_flags: got %b expected 010", {pronto, erro, aguardandoDestino}); end
        testsRun++; if (codigoErro !== 2'b10) begin failCount++; $display("[TB] FAIL null_codigo: got %b expected 10", codigoErro); end
        testsRun++; if (destino !== 6'o54 || contaJogadas !== 8'd1) begin failCount++; $display("[TB] FAIL null_hold: got %o/%0d expected 54/1", destino, contaJogadas); end
    endtask

    task automatic test_range();
        applyStimulus(1'b1, 4'd9, 4'd0, 1'b0, 1'b0);
        testsRun++; if ({erro, aguardandoDestino, codigoErro} !== 4'b1001) begin failCount++; $display("[TB] FAIL range_origem: got %b expected 1001", {erro, aguardandoDestino, codigoErro}); end
        testsRun++; if (origem !== 6'o33) begin failCount++; $display("[TB] FAIL range_origem_hold: got %o expected 33", origem); end
        applyStimulus(1'b1, 4'd2, 4'd2, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd2, 4'd8, 1'b0, 1'b0);
        testsRun++; if ({pronto, erro, aguardandoDestino, codigoErro} !== 5'b01001) begin failCount++; $display("[TB] FAIL range_destino: got %b expected 01001", {pronto, erro, aguardandoDestino, codigoErro}); end
    endtask

    task automatic test_timeout();
        applyStimulus(1'b1, 4'd5, 4'd6, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
        testsRun++; if ({erro, aguardandoDestino} !== 2'b01) begin failCount++; $display("[TB] FAIL timeout_early: got %b expected 01", {erro, aguardandoDestino}); end
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
        testsRun++; if ({pronto, erro, aguardandoDestino, codigoErro} !== 5'b01011) begin failCount++; $display("[TB] FAIL timeout_fire: got %b expected 01011", {pronto, erro, aguardandoDestino, codigoErro}); end
        applyStimulus(1'b1, 4'd2, 4'd3, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd7, 4'd7, 1'b0, 1'b0);
        testsRun++; if ({pronto, erro, aguardandoDestino} !== 3'b100) begin failCount++; $display("[TB] FAIL timeout_strobe: got %b expected 100", {pronto, erro, aguardandoDestino}); end
        testsRun++; if (destino !== 6'o77 || contaJogadas !== 8'd2) begin failCount++; $display("[TB] FAIL timeout_strobe_move: got %o/%0d expected 77/2", destino, contaJogadas); end
    endtask

    task automatic test_back_to_back();
        applyStimulus(1'b1, 4'd1, 4'd1, 1'b0, 1'b0);
        testsRun++; if ({pronto, aguardandoDestino} !== 2'b01 || origem !== 6'o11) begin failCount++; $display("[TB] FAIL b2b_origem: got %b/%o expected 01/11", {pronto, aguardandoDestino}, origem); end
    endtask

    task automatic test_cancel_reset();
        applyStimulus(1'b1, 4'd6, 4'd6, 1'b1, 1'b0);
        testsRun++; if ({pronto, erro, aguardandoDestino} !== 3'b000) begin failCount++; $display("[TB] FAIL cancel_flags: got %b expected 000", {pronto, erro, aguardandoDestino}); end
        testsRun++; if (destino !== 6'o77 || codigoErro !== 2'b11) begin failCount++; $display("[TB] FAIL cancel_hold: got %o/%b expected 77/11", destino, codigoErro); end
        applyStimulus(1'b1, 4'd4, 4'd4, 1'b1, 1'b0);
        testsRun++; if (aguardandoDestino !== 1'b1 || origem !== 6'o44) begin failCount++; $display("[TB] FAIL cancel_ignored: got %b/%o expected 1/44", aguardandoDestino, origem); end
        applyStimulus(1'b1, 4'd0, 4'd0, 1'b0, 1'b1);
        testsRun++; if ({origem, destino, pronto, erro, codigoErro, aguardandoDestino, contaJogadas} !== 25'd0) begin failCount++; $display("[TB] FAIL midreset: got %o/%o/%b%b/%b/%b/%0d expected all zero", origem, destino, pronto, erro, codigoErro, aguardandoDestino, contaJogadas); end
    endtask

    task automatic test_wrap();
        for (int i = 1; i <= 256; i++) begin
            applyStimulus(1'b1, 4'd0, 4'd0, 1'b0, 1'b0);
            testsRun++; if (pronto !== 1'b0) begin failCount++; $display("[TB] FAIL wrap_origin_pulse: move %0d got %b expected 0", i, pronto); end
            applyStimulus(1'b1, 4'd1, 4'd0, 1'b0, 1'b0);
            testsRun++; if (pronto !== 1'b1 || contaJogadas !== 8'(i)) begin failCount++; $display("[TB] FAIL wrap_move: move %0d got %b/%0d expected 1/%0d", i, pronto, contaJogadas, i % 256); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_move();
        test_null_move();
        test_range();
        test_timeout();
        test_back_to_back();
        test_cancel_reset();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
